// File: rtl/hit_miss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hit_miss_pkg
//  Description : Shared types and constants for the hit-or-miss round
//                controller: FSM state encoding, field width, the token
//                value reported for a missed round, and a one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hit_miss_pkg;

  // Width of LED, switch, score and token fields
  localparam int DATA_W = 8;

  // Token fed back to the randomizer when a round is lost
  localparam logic [DATA_W-1:0] TOKEN_MISS = 8'hFF;

  // Round sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_SPAWN = 3'd2,
    S_ARM   = 3'd3,
    S_WAIT  = 3'd4,
    S_JUDGE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [DATA_W-1:0] v);
    return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides the clock into reaction-time units. While enabled,
//                o_tick is high for one cycle out of every TICK_DIV cycles;
//                the first tick arrives TICK_DIV cycles after a clear.
//  Ports       : clk, rst    - clock and synchronous active-high reset
//                i_clr       - synchronous clear (wins over i_en)
//                i_en        - count enable
//                o_tick      - one-cycle tick, only while enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [31:0] C_LAST = 32'(TICK_DIV - 1);

  logic [31:0] r_cnt;

  // The tick fires in the last cycle of each TICK_DIV-long period, so a
  // consumer counting ticks sees floor(k/TICK_DIV) during enabled cycle k.
  assign o_tick = i_en && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hit_miss_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hit_miss_round_ctrl
//  Description : Sequences one game of the hit-or-miss LED game. Paces spawn
//                pulses to the LED randomizer, captures the lit target,
//                times the player's reaction on the switches, judges each
//                round and keeps the score. The last reaction time is fed
//                back to the randomizer as its token entropy input.
//  Ports       : clk, rst     - clock and synchronous active-high reset
//                start        - begin a new game (IDLE/DONE only)
//                sw           - debounced player switches
//                led_target   - randomizer LED output, expected one-hot
//                spawn        - one-cycle pulse to randomizer freq input
//                token        - last reaction time (FF after a miss)
//                score/misses - hits and misses this game
//                hit/miss     - one-cycle round result pulses
//                fault        - one-cycle pulse on a voided round
//                busy         - game in progress
//                game_over    - all rounds played
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_miss_round_ctrl
  import hit_miss_pkg::*;
#(
  parameter int SPAWN_GAP  = 50_000_000,
  parameter int LIT_CYCLES = 50_000_000,
  parameter int TICK_DIV   = 200_000,
  parameter int ROUNDS     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] sw,
  input  logic [DATA_W-1:0] led_target,
  output logic              spawn,
  output logic [DATA_W-1:0] token,
  output logic [DATA_W-1:0] score,
  output logic [DATA_W-1:0] misses,
  output logic              hit,
  output logic              miss,
  output logic              fault,
  output logic              busy,
  output logic              game_over
);

  localparam logic [31:0]       C_GAP_LAST = 32'(SPAWN_GAP - 1);
  localparam logic [31:0]       C_WIN_LAST = 32'(LIT_CYCLES - 1);
  localparam logic [DATA_W-1:0] C_ROUNDS   = DATA_W'(ROUNDS);
  localparam logic [DATA_W-1:0] C_SAT      = '1;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e            r_state;
  logic [31:0]       r_gap_cnt;
  logic [31:0]       r_win_cnt;
  logic [DATA_W-1:0] r_react;
  logic [DATA_W-1:0] r_target;
  logic [DATA_W-1:0] r_sw_q;
  logic [DATA_W-1:0] r_token;
  logic [DATA_W-1:0] r_score;
  logic [DATA_W-1:0] r_misses;
  logic [DATA_W-1:0] r_round;
  logic              r_fault;
  logic              r_last_hit;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rise;
  logic              w_edge;
  logic              w_in_wait;
  logic              w_timeout;
  logic              w_decide;
  logic              w_is_hit;
  logic              w_tick;
  logic              w_presc_clr;

  // sw_q follows sw every cycle, so a switch already high when WAIT begins
  // produces no rise and cannot score.
  assign w_rise      = sw & ~r_sw_q;
  assign w_edge      = (w_rise != '0);
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_timeout   = (r_win_cnt == C_WIN_LAST);
  // An edge in the final window cycle is judged as an edge, not a timeout.
  assign w_decide    = w_in_wait && (w_edge || w_timeout);
  // Multiple simultaneous rises never equal a one-hot target.
  assign w_is_hit    = w_edge && (w_rise == r_target);
  assign w_presc_clr = (r_state == S_ARM);

  // --------------------------------------------------------------------------
  // Reaction-time prescaler
  // --------------------------------------------------------------------------
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_presc_clr),
    .i_en   (w_in_wait),
    .o_tick (w_tick)
  );

  // --------------------------------------------------------------------------
  // Switch edge detector
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_q <= '0;
    end else begin
      r_sw_q <= sw;
    end
  end

  // --------------------------------------------------------------------------
  // Gap counter: restarted on every entry into GAP
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt + 32'd1;
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Window and reaction counters: cleared in ARM, run during WAIT
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_react   <= '0;
    end else if (r_state == S_ARM) begin
      r_win_cnt <= '0;
      r_react   <= '0;
    end else if (w_in_wait) begin
      r_win_cnt <= r_win_cnt + 32'd1;
      if (w_tick && (r_react != C_SAT)) begin
        r_react <= r_react + DATA_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round FSM, target capture, scoring
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_token    <= '0;
      r_score    <= '0;
      r_misses   <= '0;
      r_round    <= '0;
      r_fault    <= 1'b0;
      r_last_hit <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // token survives a restart so the randomizer keeps its entropy
          if (start) begin
            r_score  <= '0;
            r_misses <= '0;
            r_round  <= '0;
            r_state  <= S_GAP;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == C_GAP_LAST) begin
            r_state <= S_SPAWN;
          end
        end

        S_SPAWN: begin
          r_state <= S_ARM;
        end

        S_ARM: begin
          // The randomizer LED is valid the cycle after spawn, i.e. now.
          r_target <= led_target;
          if (is_onehot(led_target)) begin
            r_state <= S_WAIT;
          end else begin
            // Voided round: the round counter is left untouched.
            r_fault <= 1'b1;
            r_state <= S_GAP;
          end
        end

        S_WAIT: begin
          // Scores update on entry to JUDGE so they change together with
          // the hit/miss pulse.
          if (w_decide) begin
            r_round    <= r_round + DATA_W'(1);
            r_last_hit <= w_is_hit;
            if (w_is_hit) begin
              r_score <= r_score + DATA_W'(1);
              r_token <= r_react;
            end else begin
              r_misses <= r_misses + DATA_W'(1);
              r_token  <= TOKEN_MISS;
            end
            r_state <= S_JUDGE;
          end
        end

        S_JUDGE: begin
          if (r_round == C_ROUNDS) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_GAP;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign spawn     = (r_state == S_SPAWN);
  assign hit       = (r_state == S_JUDGE) && r_last_hit;
  assign miss      = (r_state == S_JUDGE) && !r_last_hit;
  assign fault     = r_fault;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign game_over = (r_state == S_DONE);
  assign token     = r_token;
  assign score     = r_score;
  assign misses    = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_hit_miss_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hit_miss_round_ctrl
//  Description : Self-checking bench for hit_miss_round_ctrl. Plays directed
//                and random rounds against a round-level model of the game.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_miss_round_ctrl;

  localparam int SG  = 4;
  localparam int LIT = 16;
  localparam int TD  = 2;
  localparam int NR  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] sw;
  logic [7:0] led_target;
  logic       spawn;
  logic [7:0] token;
  logic [7:0] score;
  logic [7:0] misses;
  logic       hit;
  logic       miss;
  logic       fault;
  logic       busy;
  logic       game_over;

  always #5 clk = ~clk;

  hit_miss_round_ctrl #(
    .SPAWN_GAP  (SG),
    .LIT_CYCLES (LIT),
    .TICK_DIV   (TD),
    .ROUNDS     (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sw         (sw),
    .led_target (led_target),
    .spawn      (spawn),
    .token      (token),
    .score      (score),
    .misses     (misses),
    .hit        (hit),
    .miss       (miss),
    .fault      (fault),
    .busy       (busy),
    .game_over  (game_over)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Game model
  int         m_score;
  int         m_misses;
  int         m_rounds;
  logic [7:0] m_token;
  int         next_gap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_spawn"},  spawn,     0);
    check_eq({tag, "_hit"},    hit,       0);
    check_eq({tag, "_miss"},   miss,      0);
    check_eq({tag, "_fault"},  fault,     0);
    check_eq({tag, "_busy"},   busy,      0);
    check_eq({tag, "_over"},   game_over, 0);
    check_eq({tag, "_token"},  token,     0);
    check_eq({tag, "_score"},  score,     0);
    check_eq({tag, "_misses"}, misses,    0);
  endtask

  // Number of cycles from now until spawn is seen must equal exp_steps.
  task automatic wait_spawn(input int exp_steps);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (spawn !== 1'b1 && n < exp_steps + 8);
    check_eq("spawn_latency", n, exp_steps);
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    m_score  = 0;
    m_misses = 0;
    m_rounds = 0;
    check_eq("start_busy",   busy,      1);
    check_eq("start_over",   game_over, 0);
    check_eq("start_score",  score,     0);
    check_eq("start_misses", misses,    0);
    check_eq("start_token",  token,     m_token);
    next_gap = SG;
  endtask

  // One round: target shown, switches 'held' from before WAIT, 'pat' driven
  // onto the switches at WAIT cycle k (k >= LIT means never).
  task automatic run_round(input logic [7:0] tgt, input logic [7:0] held,
                           input logic [7:0] pat, input int k);
    logic [7:0] eff;
    logic       exp_hit;
    logic       early;
    int         dec;
    int         react;
    wait_spawn(next_gap);
    sw         = held;
    led_target = tgt;
    step();  // ARM
    check_eq("spawn_width", spawn, 0);
    step();  // first GAP cycle after a void, else WAIT k=0
    if (!$onehot(tgt)) begin
      check_eq("void_fault",  fault,  1);
      check_eq("void_result", {hit, miss}, 0);
      check_eq("void_score",  score,  m_score);
      check_eq("void_misses", misses, m_misses);
      check_eq("void_busy",   busy,   1);
      next_gap = SG;
      return;
    end
    check_eq("fault_quiet", fault, 0);
    eff   = (k < LIT) ? (pat & ~held) : 8'h00;
    dec   = (eff != 8'h00) ? k : LIT - 1;
    early = 1'b0;
    for (int c = 0; c <= dec; c++) begin
      if (c == k) sw = held | pat;
      early = early | hit | miss;
      step();
    end
    check_eq("early_result", early, 0);
    // JUDGE cycle
    exp_hit = (eff == tgt);
    m_rounds++;
    if (exp_hit) begin
      m_score++;
      react   = k / TD;
      m_token = (react > 255) ? 8'd255 : 8'(react);
    end else begin
      m_misses++;
      m_token = 8'hFF;
    end
    check_eq("judge_hit",    hit,    exp_hit);
    check_eq("judge_miss",   miss,   !exp_hit);
    check_eq("judge_score",  score,  m_score);
    check_eq("judge_misses", misses, m_misses);
    check_eq("judge_token",  token,  m_token);
    // Late switch activity outside WAIT must be ignored
    sw = 8'hFF;
    step();
    check_eq("post_result", {hit, miss}, 0);
    check_eq("post_score",  score,  m_score);
    check_eq("post_misses", misses, m_misses);
    check_eq("post_token",  token,  m_token);
    if (m_rounds == NR) begin
      check_eq("end_over", game_over, 1);
      check_eq("end_busy", busy,      0);
    end else begin
      check_eq("mid_over", game_over, 0);
      check_eq("mid_busy", busy,      1);
    end
    sw       = 8'h00;
    next_gap = SG;
  endtask

  task automatic random_round();
    int         scen;
    int         b;
    int         ob;
    int         k;
    logic [7:0] tgt;
    logic [7:0] other;
    scen  = $urandom_range(0, 5);
    b     = $urandom_range(0, 7);
    ob    = (b + $urandom_range(1, 7)) % 8;
    k     = $urandom_range(0, LIT - 1);
    tgt   = 8'h01 << b;
    other = 8'h01 << ob;
    case (scen)
      0: run_round(tgt, 8'h00, tgt, k);
      1: run_round(tgt, 8'h00, other, k);
      2: run_round(tgt, 8'h00, tgt | other, k);
      3: run_round(tgt, 8'h00, 8'h00, LIT);
      4: run_round(tgt, tgt, tgt, k);
      default: run_round(($urandom_range(0, 1) == 1) ? 8'h00 : (tgt | other), 8'h00, 8'h00, LIT);
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    sw         = 8'h00;
    led_target = 8'h00;
    m_token    = 8'h00;
    step();
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check_eq("idle_busy", busy, 0);

    // Game 1: hit at k=7, wrong switch, void, timeout
    start_game();
    run_round(8'h10, 8'h00, 8'h10, 7);
    check_eq("tp1_token", token, 3);
    run_round(8'h04, 8'h00, 8'h02, 5);
    run_round(8'h00, 8'h00, 8'h00, LIT);
    run_round(8'h20, 8'h00, 8'h00, LIT);

    // Game 2: last-cycle hit, held switch, simultaneous edges
    start_game();
    run_round(8'h01, 8'h00, 8'h01, 15);
    run_round(8'h04, 8'h04, 8'h04, 3);
    run_round(8'h04, 8'h00, 8'h06, 4);

    // Random games
    for (int g = 0; g < 5; g++) begin
      start_game();
      while (m_rounds < NR) random_round();
    end

    // Reset in the middle of WAIT
    start_game();
    wait_spawn(next_gap);
    led_target = 8'h08;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst     = 1'b0;
    m_token = 8'h00;
    step();
    step();
    check_eq("midrst_idle_busy",  busy,  0);
    check_eq("midrst_idle_spawn", spawn, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hit_miss_round_ctrl.md
# hit_miss_round_ctrl

- Sequences one game of the hit-or-miss LED game.
- Paces spawn pulses into the LED randomizer's `freq` input.
- Captures the lit target LED and measures the player's reaction time on the switches.
- Judges each round as hit or miss, keeps score, and feeds the reaction time back as the randomizer's `token` entropy input.
- Sits between the switch/debounce front end and the randomizer, and drives the score display logic.

## Interface

**Parameters**

- `SPAWN_GAP`, default 50_000_000: idle cycles between rounds (≥1).
- `LIT_CYCLES`, default 50_000_000: response window length in cycles (≥2).
- `TICK_DIV`, default 200_000: clock cycles per reaction-time unit (≥1).
- `ROUNDS`, default 10: rounds per game (1..255).

**Ports**

- `clk`, input, 1: single system clock. One clock; reset is synchronous and active-high.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: level, sampled only in IDLE/DONE; begins a new game.
- `sw`, input, 8: debounced player switches.
- `led_target`, input, 8: randomizer LED output (expected one-hot).
- `spawn`, output, 1: one-cycle pulse, wired to randomizer `freq`.
- `token`, output, 8: last reaction time, wired to randomizer `token`.
- `score`, output, 8: hits this game.
- `misses`, output, 8: misses this game.
- `hit`, output, 1: one-cycle round-result pulse.
- `miss`, output, 1: one-cycle round-result pulse.
- `fault`, output, 1: one-cycle pulse on a voided round.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `game_over`, output, 1: high in DONE.

## Operation

**States:** IDLE, GAP, SPAWN, ARM, WAIT, JUDGE, DONE.

- **IDLE/DONE:** `start`=1 clears `score`, `misses` and the round counter, then goes to GAP. `token` is kept.
- **GAP:** the gap counter runs for SPAWN_GAP cycles, then goes to SPAWN.
- **SPAWN:** `spawn`=1 for exactly this cycle, then goes to ARM.
- **ARM:** latch `target` = `led_target`.
  - Not exactly one-hot (zero or multi-hot): `fault` pulses on the next cycle, the round is voided (round counter unchanged), and the FSM returns to GAP.
  - One-hot: clear the reaction counter and tick prescaler, then go to WAIT.
- **WAIT:**
  - The reaction counter increments once every TICK_DIV cycles and saturates at 255.
  - The window counter counts WAIT cycles.
  - Rising edge: `rise` = `sw` & ~`sw_q`, where `sw_q` is registered every cycle with reset value 0.
  - `rise` ≠ 0 → result is hit if `rise` == `target`, else miss (wrong switch or multiple switches). Go to JUDGE.
  - Window reaches LIT_CYCLES with no edge → miss (timeout). Go to JUDGE.
  - An edge in the final window cycle beats the timeout.
  - A switch already high when WAIT is entered does not count.
- **JUDGE:** one cycle.
  - Hit: `hit`=1, `score`+1, `token` = reaction counter.
  - Miss: `miss`=1, `misses`+1, `token` = 8'hFF.
  - Round counter +1. If it equals ROUNDS, go to DONE; else go to GAP.
- **Other rules:**
  - `start` is ignored outside IDLE/DONE.
  - `sw` is ignored outside WAIT.
  - `score` + `misses` never exceeds ROUNDS, so no overflow is possible.

## Timing

- **Reset values:** state=IDLE; `spawn`, `hit`, `miss`, `fault`, `busy`, `game_over` = 0; `token`, `score`, `misses`, `target`, counters, `sw_q` = 0.
- **Reset mid-game:** returns to IDLE within one cycle. No result pulse is emitted, and any spawn in flight is dropped.
- **Start latency:** `start` sampled in cycle 0 → GAP covers cycles 1..SPAWN_GAP → `spawn` is high in cycle SPAWN_GAP+1 → ARM in SPAWN_GAP+2. The randomizer LED is valid one cycle after `spawn`.
- **Reaction value:** the first edge in WAIT cycle k (k=0 is the first WAIT cycle) gives `token` = min(floor(k/TICK_DIV), 255).
- **Result latency:** JUDGE is the cycle after the decisive WAIT cycle. `hit`/`miss`, `score`, `misses` and `token` all change in that cycle.
- **Round period:** without an edge, one round is SPAWN_GAP + 2 + LIT_CYCLES + 1 cycles.
- **End of game:** `game_over` rises the cycle after the last JUDGE. `busy` falls at the same time.

## Structure

- **Package `hit_miss_pkg`:**
  - State enum.
  - `TOKEN_MISS` = 8'hFF.
  - Width constant 8 for the LED/switch/score fields.
- **Sub-module `tick_prescaler`:**
  - Synchronous clear and enable.
  - Emits a one-cycle tick every TICK_DIV cycles.
  - Drives the reaction counter.
- **Top level:** FSM, gap/window counters, edge detector and score registers.

## Test plan

Bench parameters: SPAWN_GAP=4, LIT_CYCLES=16, TICK_DIV=2, ROUNDS=3.

1. **Correct hit.** Reset, `start` in cycle 0. `spawn` high in cycle 5 only. `led_target`=8'h10. `sw[4]` rises in WAIT k=7 → `hit` pulse, `token`=3, `score`=1, `misses`=0.
2. **Wrong switch.** Target 8'h04 and `sw[1]` rises → `miss`, `token`=8'hFF, `misses`=1. A second edge in the same window is ignored.
3. **Timeout vs. last-cycle edge.** No `sw` activity → `miss` one cycle after the 16th WAIT cycle. Separate run: a correct edge at k=15 → `hit`, `token`=7.
4. **Held switch and simultaneous edges.** `sw[2]` held high before WAIT with target 8'h04, no new edge → timeout miss. Separate run: `sw` rising 8'h06 in one cycle → miss.
5. **Voided round.** `led_target`=8'h00 in ARM → `fault` pulse, no `hit`/`miss`, round count unchanged, next `spawn` SPAWN_GAP+2 cycles later.
6. **Full game and reset.** Three rounds → `game_over`=1, `busy`=0. `start` restarts with `score`=`misses`=0. `rst` asserted mid-WAIT → next cycle shows IDLE and all outputs at reset values.
